// File: rtl/timer_access_ctrl_pkg.sv
// Shared types and constants for the machine-timer access sequencer.
package timer_ctrl_pkg;

    // Command opcode carried on req_op.
    typedef enum logic {
        SET_CMP = 1'b0,
        SET_EN  = 1'b1
    } op_e;

    // Sequencer states; each WR_* state spans one strobe phase.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR_L1 = 3'd1,
        WR_H  = 3'd2,
        WR_L2 = 3'd3,
        WR_EN = 3'd4,
        DONE  = 3'd5
    } state_e;

    // Low word parked at all-ones while the high word changes, so the
    // 64-bit compare value can never drop below its old or new value.
    localparam logic [31:0] CMP_SAFE_L = 32'hFFFF_FFFF;
    localparam logic [31:0] CMP_SAFE_H = 32'hFFFF_FFFF;

    // Width of an index into n requesters (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/timer_access_ctrl_if.sv
// Requester command bus plus the strobe/data bus toward the timer.
interface timer_access_ctrl_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_op;
    logic [NUM_REQ*64-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    req_done;
    logic                  busy;
    logic                  tmr_en;
    logic                  tmr_wr_en;
    logic                  tmr_wr_cmp_l;
    logic                  tmr_wr_cmp_h;
    logic [31:0]           tmr_cmp_l;
    logic [31:0]           tmr_cmp_h;

    // Requester side: issues commands, observes handshakes and timer writes.
    modport master (
        output req_valid, req_op, req_data,
        input  req_ready, req_done, busy,
        input  tmr_en, tmr_wr_en, tmr_wr_cmp_l, tmr_wr_cmp_h, tmr_cmp_l, tmr_cmp_h
    );

    // Sequencer side.
    modport slave (
        input  req_valid, req_op, req_data,
        output req_ready, req_done, busy,
        output tmr_en, tmr_wr_en, tmr_wr_cmp_l, tmr_wr_cmp_h, tmr_cmp_l, tmr_cmp_h
    );
endinterface

// File: rtl/timer_access_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requesting bit at or
// after ptr, wrapping around. The pointer register is owned by the parent.
module rr_arbiter
    import timer_ctrl_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W:0]   pos;
    logic [IDX_W-1:0] cand;
    logic             found;

    // Scan N positions starting at ptr; the first set request wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = '0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            pos = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (pos >= (IDX_W + 1)'(N)) begin
                pos = pos - (IDX_W + 1)'(N);
            end
            cand = pos[IDX_W-1:0];
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/timer_access_ctrl.sv
// Arbitrated command sequencer in front of the machine timer. Grants one
// requester at a time and converts its command into spaced single-cycle
// write strobes. Compare updates use the low/high/low order so the timer's
// comparator never sees a transient value below the old or new compare.
module timer_access_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int HOLD_CYC = 2
) (
    input  logic                CLK,
    input  logic                RST_N,
    timer_access_ctrl_if.slave  bus
);

    localparam int               IDX_W    = idx_width(NUM_REQ);
    localparam int               CNT_W    = $clog2(1 + HOLD_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    state_e               state;
    logic [IDX_W-1:0]     ptr;
    logic [CNT_W-1:0]     phase_cnt;
    logic [NUM_REQ-1:0]   gnt_oh;
    logic [63:0]          cmd_data;

    logic [NUM_REQ-1:0]   req_ready_r;
    logic [NUM_REQ-1:0]   req_done_r;
    logic                 busy_r;
    logic                 tmr_en_r;
    logic                 wr_en_r;
    logic                 wr_cmp_l_r;
    logic                 wr_cmp_h_r;
    logic [31:0]          cmp_l_r;
    logic [31:0]          cmp_h_r;

    logic [NUM_REQ-1:0]   arb_grant;
    logic [IDX_W-1:0]     arb_idx;
    logic                 in_phase;
    logic                 phase_first;
    logic                 phase_last;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req       (bus.req_valid),
        .ptr       (ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    assign in_phase    = state inside {WR_L1, WR_H, WR_L2, WR_EN};
    assign phase_first = (phase_cnt == '0);
    assign phase_last  = (phase_cnt == CNT_LAST);

    // Sequencer FSM with all outputs registered. The state names the phase
    // whose outputs are produced at the next edge, so the first strobe lands
    // one cycle after the req_ready pulse.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            ptr         <= '0;
            phase_cnt   <= '0;
            gnt_oh      <= '0;
            cmd_data    <= '0;
            req_ready_r <= '0;
            req_done_r  <= '0;
            busy_r      <= 1'b0;
            tmr_en_r    <= 1'b0;
            wr_en_r     <= 1'b0;
            wr_cmp_l_r  <= 1'b0;
            wr_cmp_h_r  <= 1'b0;
            cmp_l_r     <= CMP_SAFE_L;
            cmp_h_r     <= CMP_SAFE_H;
        end else begin
            // Pulses default low; the state below raises the one it needs.
            req_ready_r <= '0;
            req_done_r  <= '0;
            wr_en_r     <= 1'b0;
            wr_cmp_l_r  <= 1'b0;
            wr_cmp_h_r  <= 1'b0;

            // Phase counter: strobe on count 0, then HOLD_CYC quiet cycles.
            if (in_phase) begin
                phase_cnt <= phase_last ? '0 : phase_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (|bus.req_valid) begin
                        req_ready_r <= arb_grant;
                        gnt_oh      <= arb_grant;
                        cmd_data    <= bus.req_data[arb_idx*64 +: 64];
                        ptr         <= (arb_idx == IDX_LAST) ? '0 : arb_idx + 1'b1;
                        busy_r      <= 1'b1;
                        phase_cnt   <= '0;
                        state       <= (op_e'(bus.req_op[arb_idx]) == SET_EN) ? WR_EN : WR_L1;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                WR_L1: begin
                    if (phase_first) begin
                        wr_cmp_l_r <= 1'b1;
                        cmp_l_r    <= CMP_SAFE_L;
                    end
                    if (phase_last) begin
                        state <= WR_H;
                    end
                end
                WR_H: begin
                    if (phase_first) begin
                        wr_cmp_h_r <= 1'b1;
                        cmp_h_r    <= cmd_data[63:32];
                    end
                    if (phase_last) begin
                        state <= WR_L2;
                    end
                end
                WR_L2: begin
                    if (phase_first) begin
                        wr_cmp_l_r <= 1'b1;
                        cmp_l_r    <= cmd_data[31:0];
                    end
                    if (phase_last) begin
                        state <= DONE;
                    end
                end
                WR_EN: begin
                    if (phase_first) begin
                        wr_en_r  <= 1'b1;
                        tmr_en_r <= cmd_data[0];
                    end
                    if (phase_last) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // busy stays high through the done pulse; IDLE drops it.
                    req_done_r <= gnt_oh;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready    = req_ready_r;
    assign bus.req_done     = req_done_r;
    assign bus.busy         = busy_r;
    assign bus.tmr_en       = tmr_en_r;
    assign bus.tmr_wr_en    = wr_en_r;
    assign bus.tmr_wr_cmp_l = wr_cmp_l_r;
    assign bus.tmr_wr_cmp_h = wr_cmp_h_r;
    assign bus.tmr_cmp_l    = cmp_l_r;
    assign bus.tmr_cmp_h    = cmp_h_r;

endmodule

// File: tb/tb_timer_access_ctrl.sv
// Scoreboard bench for timer_access_ctrl: stimulus queues the expected event
// stream (accepts, strobes with data, completions, spacing), a monitor pops
// and compares whenever the DUT shows an event. Includes a small timer model.
module tb_timer_access_ctrl;
    import timer_ctrl_pkg::*;

    localparam int NREQ = 2;
    localparam int HOLD = 2;
    localparam int PH   = 1 + HOLD;
    localparam logic [63:0] MTIME = 64'd5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    timer_access_ctrl_if #(.NUM_REQ(NREQ)) bus();

    timer_access_ctrl #(
        .NUM_REQ  (NREQ),
        .HOLD_CYC (HOLD)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    typedef enum int {EV_RDY, EV_WR_L, EV_WR_H, EV_WR_EN, EV_DONE} ev_e;
    typedef struct {
        ev_e         kind;
        logic [63:0] val;
        int          gap;
        string       tag;
    } exp_t;

    exp_t  sb[$];
    int    checks   = 0;
    int    errors   = 0;
    int    cyc      = 0;
    int    last_evt = 0;
    int    done_cnt = 0;
    string tag      = "por";

    // Timer model sharing the reset net: compare register written by strobes.
    logic [63:0] mtcmp;
    logic        timer_int;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mtcmp <= '1;
        else begin
            if (bus.tmr_wr_cmp_l) mtcmp[31:0]  <= bus.tmr_cmp_l;
            if (bus.tmr_wr_cmp_h) mtcmp[63:32] <= bus.tmr_cmp_h;
        end
    end
    assign timer_int = bus.tmr_en && (MTIME >= mtcmp);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%s]: got %0h, expected %0h", name, tag, act, exp);
        end
    endtask

    task automatic push(input ev_e k, input logic [63:0] v, input int g);
        exp_t e;
        e.kind = k; e.val = v; e.gap = g; e.tag = tag;
        sb.push_back(e);
    endtask

    // Expected event stream of one command; gaps are cycles since the
    // previous event (-1 = not checked).
    task automatic push_cmd(input int idx, input op_e op, input logic [63:0] d, input int rgap);
        push(EV_RDY, 64'(idx), rgap);
        if (op == SET_CMP) begin
            push(EV_WR_L, 64'hFFFF_FFFF, 1);
            push(EV_WR_H, {32'h0, d[63:32]}, PH);
            push(EV_WR_L, {32'h0, d[31:0]}, PH);
        end else begin
            push(EV_WR_EN, {63'h0, d[0]}, 1);
        end
        push(EV_DONE, 64'(idx), PH);
    endtask

    task automatic observe(input ev_e k, input logic [63:0] v);
        exp_t e;
        int   gap;
        gap = cyc - last_evt;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event [%s]: got %s val=%0h, expected nothing", tag, k.name(), v);
        end else begin
            e = sb.pop_front();
            if (e.kind != k || e.val !== v || (e.gap >= 0 && gap != e.gap)) begin
                errors++;
                $display("FAIL event [%s]: got %s val=%0h gap=%0d, expected %s val=%0h gap=%0d",
                         e.tag, k.name(), v, gap, e.kind.name(), e.val, e.gap);
            end
        end
        last_evt = cyc;
    endtask

    function automatic logic [63:0] onehot_idx(input logic [NREQ-1:0] v);
        if (!$onehot(v)) return 64'd99;
        for (int i = 0; i < NREQ; i++) if (v[i]) return 64'(i);
        return 64'd99;
    endfunction

    // Monitor: turns DUT pulses into events and checks data stability.
    logic [31:0] prev_l, prev_h;
    logic        prev_en;
    logic        prev_ok = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_ok = 1'b0;
        end else begin
            if (prev_ok && bus.tmr_cmp_l !== prev_l) chk("cmp_l changes only on strobe", bus.tmr_wr_cmp_l, 1);
            if (prev_ok && bus.tmr_cmp_h !== prev_h) chk("cmp_h changes only on strobe", bus.tmr_wr_cmp_h, 1);
            if (prev_ok && bus.tmr_en !== prev_en)   chk("tmr_en changes only on strobe", bus.tmr_wr_en, 1);
            if (bus.req_ready != '0) begin
                observe(EV_RDY, onehot_idx(bus.req_ready));
                chk("busy at accept", bus.busy, 1);
            end
            if (bus.tmr_wr_cmp_l) observe(EV_WR_L, {32'h0, bus.tmr_cmp_l});
            if (bus.tmr_wr_cmp_h) observe(EV_WR_H, {32'h0, bus.tmr_cmp_h});
            if (bus.tmr_wr_en)    observe(EV_WR_EN, {63'h0, bus.tmr_en});
            if (bus.req_done != '0) begin
                done_cnt++;
                observe(EV_DONE, onehot_idx(bus.req_done));
                chk("busy at done", bus.busy, 1);
            end
            prev_ok = 1'b1;
        end
        prev_l  = bus.tmr_cmp_l;
        prev_h  = bus.tmr_cmp_h;
        prev_en = bus.tmr_en;
    end

    // Drive one command and hold it until accepted; afterwards the payload
    // is scrambled to prove the DUT latched it.
    task automatic issue(input int idx, input op_e op, input logic [63:0] d);
        bit got = 1'b0;
        bus.req_valid[idx]         = 1'b1;
        bus.req_op[idx]            = op;
        bus.req_data[idx*64 +: 64] = d;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.req_ready[idx]) begin got = 1'b1; break; end
        end
        bus.req_valid[idx]         = 1'b0;
        bus.req_op[idx]            = ~op;
        bus.req_data[idx*64 +: 64] = ~d;
        chk("accept within budget", got, 1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.busy) begin ok = 1'b1; break; end
        end
        chk("sequence completes and busy drops", ok, 1);
    endtask

    task automatic chk_reset_vals();
        chk("rst req_ready", bus.req_ready, 0);
        chk("rst req_done", bus.req_done, 0);
        chk("rst busy", bus.busy, 0);
        chk("rst tmr_en", bus.tmr_en, 0);
        chk("rst strobes", {bus.tmr_wr_en, bus.tmr_wr_cmp_l, bus.tmr_wr_cmp_h}, 0);
        chk("rst tmr_cmp_l", bus.tmr_cmp_l, 32'hFFFF_FFFF);
        chk("rst tmr_cmp_h", bus.tmr_cmp_h, 32'hFFFF_FFFF);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog [%s]: got timeout, expected completion", tag);
        $fatal(1, "watchdog");
    end

    initial begin
        bit   bad;
        bit   seen;
        bit   early;
        int   l_seen;
        int   d0;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_data  = '0;

        // Power-on reset and quiet idle.
        repeat (3) @(negedge clk);
        chk_reset_vals();
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.busy || bus.tmr_wr_en || bus.tmr_wr_cmp_l || bus.tmr_wr_cmp_h) bad = 1'b1;
        end
        chk("idle stays quiet", bad, 0);
        chk("idle cmp_l", bus.tmr_cmp_l, 32'hFFFF_FFFF);
        chk("idle cmp_h", bus.tmr_cmp_h, 32'hFFFF_FFFF);

        // Single compare update from requester 0.
        tag = "cmp0";
        push_cmd(0, SET_CMP, 64'h0000_0001_0000_0020, -1);
        issue(0, SET_CMP, 64'h0000_0001_0000_0020);
        wait_idle();
        chk("cmp_l after update", bus.tmr_cmp_l, 32'h0000_0020);
        chk("cmp_h after update", bus.tmr_cmp_h, 32'h0000_0001);

        // Enable from requester 1.
        tag = "en1";
        push_cmd(1, SET_EN, 64'h1, -1);
        issue(1, SET_EN, 64'h1);
        wait_idle();
        chk("tmr_en level", bus.tmr_en, 1);
        chk("cmp_l untouched by enable", bus.tmr_cmp_l, 32'h0000_0020);

        // Both requesters pending together: 0, 1, 0, 1 back-to-back.
        tag = "rr";
        push_cmd(0, SET_CMP, 64'hAAAA_0000_5555_0001, -1);
        push_cmd(1, SET_EN,  64'h0, 1);
        push_cmd(0, SET_EN,  64'h1, 1);
        push_cmd(1, SET_CMP, 64'h1234_5678_9ABC_DEF0, 1);
        fork
            begin
                issue(0, SET_CMP, 64'hAAAA_0000_5555_0001);
                @(negedge clk);
                issue(0, SET_EN, 64'h1);
            end
            begin
                issue(1, SET_EN, 64'h0);
                @(negedge clk);
                issue(1, SET_CMP, 64'h1234_5678_9ABC_DEF0);
            end
        join
        wait_idle();
        chk("rr final cmp_h", bus.tmr_cmp_h, 32'h1234_5678);
        chk("rr final cmp_l", bus.tmr_cmp_l, 32'h9ABC_DEF0);
        chk("rr final tmr_en", bus.tmr_en, 1);

        // Reset in the middle of the high-word phase.
        tag = "rst_mid";
        push_cmd(0, SET_CMP, 64'h0000_0003_0000_0040, -1);
        issue(0, SET_CMP, 64'h0000_0003_0000_0040);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.tmr_wr_cmp_h) begin seen = 1'b1; break; end
        end
        chk("reached high-word phase", seen, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals();
        sb.delete();
        d0 = done_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("no done after abort", done_cnt - d0, 0);
        chk("busy low after abort", bus.busy, 0);

        tag = "after_rst";
        push_cmd(0, SET_CMP, 64'h0000_0002_0000_0000, -1);
        issue(0, SET_CMP, 64'h0000_0002_0000_0000);
        wait_idle();
        chk("cmp_h after recovery", bus.tmr_cmp_h, 32'h0000_0002);
        chk("cmp_l after recovery", bus.tmr_cmp_l, 32'h0000_0000);

        // Glitch-free update seen by the timer model, mtime = 5.
        tag = "en_t";
        push_cmd(1, SET_EN, 64'h1, -1);
        issue(1, SET_EN, 64'h1);
        wait_idle();
        chk("timer_int before update", timer_int, 0);
        tag = "glitch";
        push_cmd(0, SET_CMP, 64'd5, -1);
        issue(0, SET_CMP, 64'd5);
        early  = 1'b0;
        l_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (timer_int && l_seen < 2) early = 1'b1;
            if (bus.tmr_wr_cmp_l) l_seen++;
            if (bus.req_done[0]) break;
        end
        chk("no match before final low write", early, 0);
        chk("low writes in compare update", l_seen, 2);
        chk("timer_int after update", timer_int, 1);
        wait_idle();

        chk("scoreboard drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
